// File: rtl/cdc_arbiter_pkg.sv
// cdc_arbiter_pkg: shared definitions for the CDC arbiter.
//   state_e : FSM state encodings (IDLE/HOLD/GAP)
//   CNT_W   : hold counter width, wide enough for HOLD_CYCLES-1 up to 254
package cdc_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int CNT_W = 8;

endpackage

// File: rtl/cdc_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker.
//   req         : per-requester request levels
//   last_grant  : index of the most recent winner
//   grant_valid : some request is pending
//   grant_idx   : first requester at or after last_grant+1 (mod NUM_REQ)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  localparam int SW = IDX_W + 2;

  logic [2*NUM_REQ-1:0] w_sh;
  logic [NUM_REQ-1:0]   w_rot;
  logic [SW-1:0]        w_off;
  logic [SW-1:0]        w_sum;

  // Rotate so bit 0 is requester last_grant+1; a shift of NUM_REQ is identity.
  assign w_sh  = {req, req} >> ({1'b0, last_grant} + 1'b1);
  assign w_rot = w_sh[NUM_REQ-1:0];

  always_comb begin
    grant_valid = 1'b0;
    w_off       = '0;
    // Descending scan so the lowest set offset wins.
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        grant_valid = 1'b1;
        w_off       = SW'(j);
      end
    end
    w_sum = SW'(last_grant) + SW'(1) + w_off;
    if (w_sum >= SW'(NUM_REQ)) w_sum = w_sum - SW'(NUM_REQ);
    grant_idx = w_sum[IDX_W-1:0];
  end

endmodule

// File: rtl/cdc_arbiter.sv
// cdc_arbiter: round-robin arbiter feeding a hold-stable CDC data crosser.
// A granted word is held on cdc_data with cdc_valid high for HOLD_CYCLES
// cycles, then the owner gets a one-cycle ack during a one-cycle gap.
//   clk, rst     : clock, synchronous active-low reset
//   en           : permits new grants (in-flight transfers always finish)
//   req, data_in : per-requester level requests and packed words
//   ack          : one-cycle completion pulse to the owner
//   cdc_data/cdc_valid/cdc_tag : registered word, valid, owner index
//   busy         : transfer in progress (HOLD or GAP)
module cdc_arbiter
  import cdc_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         cdc_data,
  output logic                          cdc_valid,
  output logic [IDX_W-1:0]              cdc_tag,
  output logic                          busy
);

  state_e                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_last;
  logic [NUM_REQ-1:0]    r_ack;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic [IDX_W-1:0]      r_tag;
  logic                  r_busy;

  logic                  w_gv;
  logic [IDX_W-1:0]      w_gidx;
  logic [DATA_WIDTH-1:0] w_word;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req         (req),
    .last_grant  (r_last),
    .grant_valid (w_gv),
    .grant_idx   (w_gidx)
  );

  // Winner's word, selected by mux to keep the slice index simple.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gidx == IDX_W'(i)) w_word = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= IDX_W'(NUM_REQ - 1);  // requester 0 wins first
      r_ack   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= '0;
          if (en && w_gv) begin
            r_data  <= w_word;
            r_tag   <= w_gidx;
            r_last  <= w_gidx;
            r_valid <= 1'b1;
            r_cnt   <= CNT_W'(HOLD_CYCLES - 1);
            r_busy  <= 1'b1;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_valid <= 1'b0;
            r_ack   <= NUM_REQ'(1) << r_tag;
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_GAP: begin
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ack   <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign cdc_data  = r_data;
  assign cdc_valid = r_valid;
  assign cdc_tag   = r_tag;
  assign busy      = r_busy;

endmodule

// File: tb/tb_cdc_arbiter.sv
module tb_cdc_arbiter;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [N-1:0]  req;
  logic [DW-1:0] data_w [N];
  logic [N*DW-1:0] data_in;
  logic [N-1:0]  ack;
  logic [DW-1:0] cdc_data;
  logic          cdc_valid;
  logic [1:0]    cdc_tag;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int m_last;  // model: most recent completed-or-started grant

  assign data_in = {data_w[3], data_w[2], data_w[1], data_w[0]};

  always #5 clk = ~clk;

  cdc_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .HOLD_CYCLES(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .data_in   (data_in),
    .ack       (ack),
    .cdc_data  (cdc_data),
    .cdc_valid (cdc_valid),
    .cdc_tag   (cdc_tag),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin from the rule: first requester after `last`, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (((r >> j) & 4'd1) != 4'd0) return j;
    end
    return -1;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, cdc_valid, 0);
    chk({tag, "_ack"},   ack,       0);
    chk({tag, "_busy"},  busy,      0);
    chk({tag, "_data"},  cdc_data,  0);
    chk({tag, "_tag"},   cdc_tag,   0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    m_last = N - 1;
  endtask

  // Called at a negedge in IDLE with inputs set so the next posedge grants idx.
  task automatic run_xfer(input int idx, input bit drop, input bit en_mid, input bit data_mid);
    logic [DW-1:0] exp_d;
    logic [N-1:0]  exp_ack;
    exp_d   = data_w[idx];
    exp_ack = N'(1) << idx;
    for (int c = 0; c < H; c++) begin
      @(negedge clk);
      chk("hold_valid", cdc_valid, 1);
      chk("hold_tag",   cdc_tag,   idx);
      chk("hold_data",  cdc_data,  exp_d);
      chk("hold_ack",   ack,       0);
      chk("hold_busy",  busy,      1);
      if (c == 1 && en_mid)   en = 1'b0;
      if (c == 1 && data_mid) data_w[idx] = 32'hEEEEEEEE;
    end
    @(negedge clk);
    chk("gap_valid", cdc_valid, 0);
    chk("gap_ack",   ack,       exp_ack);
    chk("gap_busy",  busy,      1);
    chk("gap_data",  cdc_data,  exp_d);
    if (drop) req[idx] = 1'b0;
    @(negedge clk);
    chk("idle_valid", cdc_valid, 0);
    chk("idle_ack",   ack,       0);
    chk("idle_busy",  busy,      0);
    chk("idle_data",  cdc_data,  exp_d);
    chk("idle_tag",   cdc_tag,   idx);
    m_last = idx;
  endtask

  initial begin
    int idx;
    rst = 1'b0;
    en  = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) data_w[i] = $urandom;

    // Reset state, then a single request from requester 2.
    @(negedge clk);
    do_reset();
    data_w[2] = 32'h1234EFEF;
    req = 4'b0100;
    run_xfer(pick(req, m_last), 1, 0, 0);

    // All requesting from reset, each drops on its ack.
    do_reset();
    for (int i = 0; i < N; i++) data_w[i] = $urandom;
    req = 4'b1111;
    for (int t = 0; t < N; t++) run_xfer(pick(req, m_last), 1, 0, 0);
    chk("all_req_drained", req, 0);

    // Two requesters re-requesting continuously must alternate.
    req = 4'b1001;
    for (int t = 0; t < 6; t++) begin
      int prev;
      prev = m_last;
      idx  = pick(req, m_last);
      data_w[idx] = $urandom;
      run_xfer(idx, 0, 0, 0);
      chk("fair_no_repeat", (cdc_tag == 2'(prev)) ? 1 : 0, 0);
    end
    req = '0;

    // en gating: no grant while low, grant on the edge after it rises.
    en  = 1'b0;
    req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("en_block_valid", cdc_valid, 0);
      chk("en_block_busy",  busy,      0);
    end
    en = 1'b1;
    run_xfer(pick(req, m_last), 1, 1, 0);
    en = 1'b1;

    // data_in changes after the grant must not reach cdc_data.
    data_w[1] = 32'h1F184FE4;
    req = 4'b0010;
    run_xfer(pick(req, m_last), 1, 0, 1);

    // Reset in the second HOLD cycle aborts the transfer without credit.
    for (int i = 0; i < N; i++) data_w[i] = $urandom;
    req = 4'b1110;
    idx = pick(req, m_last);
    @(negedge clk);
    chk("abort_h1_valid", cdc_valid, 1);
    chk("abort_h1_tag",   cdc_tag,   idx);
    @(negedge clk);
    chk("abort_h2_valid", cdc_valid, 1);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("abort");
    rst = 1'b1;
    m_last = N - 1;
    run_xfer(pick(req, m_last), 1, 0, 0);

    // Randomized transfers against the model.
    for (int t = 0; t < 24; t++) begin
      req = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) data_w[i] = $urandom;
      run_xfer(pick(req, m_last), $urandom_range(0, 1) == 1, 0, 0);
    end
    req = '0;
    repeat (3) begin
      @(negedge clk);
      chk("tail_idle_busy", busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdc_arbiter.md
CDC_ARBITER -- requirements
Module: cdc_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each requester word and of the crosser data path.
REQ-002 Parameter NUM_REQ, default 4, number of requesters; legal range 2..16.
REQ-003 Parameter HOLD_CYCLES, default 4, cycles each word is held stable on cdc_data; legal range 2..255; sized for the slowest destination clock of the crosser.
REQ-004 Port clk, input, 1, single clock, source-side domain of the crosser; all logic on rising edge.
REQ-005 Port rst, input, 1, synchronous active-low reset.
REQ-006 Port en, input, 1, high permits new grants; low blocks new grants only.
REQ-007 Port req, input, NUM_REQ, per-requester level request; must stay high with its data stable until its ack.
REQ-008 Port data_in, input, NUM_REQ*DATA_WIDTH, packed requester words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port ack, output, NUM_REQ, one-cycle completion pulse per requester.
REQ-010 Port cdc_data, output, DATA_WIDTH, registered word driven to the crosser data_in.
REQ-011 Port cdc_valid, output, 1, high while cdc_data holds a word under transfer.
REQ-012 Port cdc_tag, output, clog2(NUM_REQ), index of the requester owning cdc_data.
REQ-013 Port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, HOLD, GAP; encodings from the shared include.
REQ-015 IDLE: if en=1 and req nonzero, grant by round-robin; at the same edge load cdc_data from the winner's slice, load cdc_tag, set cdc_valid=1, load hold counter with HOLD_CYCLES-1, go to HOLD.
REQ-016 Round-robin: search starts at last_grant+1 modulo NUM_REQ; last_grant updates only on a grant.
REQ-017 HOLD: counter decrements each cycle; at the edge where counter=0, clear cdc_valid, pulse ack[tag] for exactly one cycle, go to GAP.
REQ-018 cdc_valid stays high for exactly HOLD_CYCLES consecutive cycles per transfer.
REQ-019 GAP: lasts one cycle with cdc_valid=0, ack pulse visible, busy=1; next state always IDLE.
REQ-020 Minimum transfer period is HOLD_CYCLES+2 cycles: grant edge to next grant edge.
REQ-021 req sampled only in IDLE; a req deasserted during HOLD or GAP does not abort the transfer, and ack is still issued.
REQ-022 data_in sampled only at the grant edge; later changes do not affect cdc_data.
REQ-023 en low in HOLD or GAP has no effect; the current transfer completes.
REQ-024 cdc_data and cdc_tag hold their last values after a transfer until the next grant; they are not cleared.
REQ-025 At most one ack bit is high in any cycle; ack never coincides with cdc_valid=1.
REQ-026 A requester still high in the IDLE cycle after its ack is treated as a new request.

Reset
REQ-027 While rst=0 at a clock edge: state=IDLE, cdc_valid=0, ack=0, busy=0, cdc_data=0, cdc_tag=0, hold counter=0, last_grant=NUM_REQ-1 so requester 0 wins first.
REQ-028 Reset during HOLD or GAP aborts the transfer with no ack issued; the aborted requester is not credited as last_grant.

Structure
REQ-029 State encodings and counter-width constant reside in the shared include cdc_arbiter_defs.vh.
REQ-030 Round-robin selection is a combinational sub-module rr_arbiter (inputs: req, last_grant; outputs: grant_valid, grant_idx), instantiated once.
REQ-031 All outputs are registered; no combinational path from req or data_in to any output.

Verification
REQ-032 Single request: after reset, req=4'b0100, data slice 2=32'h1234EFEF -> next cycle cdc_valid=1, cdc_tag=2, cdc_data=32'h1234EFEF for 4 cycles, then ack=4'b0100 for 1 cycle.
REQ-033 All requesting: req=4'b1111 held, each dropped on its ack -> grant order 0,1,2,3, grants every 6 cycles, one ack per transfer.
REQ-034 Fairness: req0 and req3 continuously re-requesting -> grants alternate 0,3,0,3; neither is granted twice in a row.
REQ-035 en gating: en=0 with req=4'b0001 -> no cdc_valid for 10 cycles; en=1 -> grant on the next edge; en=0 mid-HOLD -> transfer completes with ack.
REQ-036 Reset mid-transfer: rst=0 on HOLD cycle 2 -> next cycle all outputs 0 and no ack; after release with req=4'b0010 still high -> requester 1 is granted.
REQ-037 Data stability: data_in slice changed to 32'hEEEEEEEE during HOLD -> cdc_data stays 32'h1F184FE4 until ack.
